// File: rtl/wb_pkg.sv
// Shared constants and FSM state encoding for the Wishbone address decoder.
package wb_pkg;

  localparam int WB_ADDR_W = 8;
  localparam int WB_DAT_W  = 8;
  localparam int WB_BLK_W  = 4;
  localparam int WB_OFS_W  = 4;
  localparam int WB_NBLK   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_e;

  function automatic logic [WB_NBLK-1:0] blk_onehot(input logic [WB_BLK_W-1:0] blk);
    return WB_NBLK'(1) << blk;
  endfunction

endpackage

// File: rtl/wb_dec_wdog.sv
// Saturating watchdog counter: cleared by clr_i, counts while en_i, flags once TIMEOUT_CYC is reached.
module wb_dec_wdog #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] cnt_q;

  // Holding at LIMIT keeps the terminal flag asserted instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_dec.sv
// Wishbone address decoder: one registered one-hot slave strobe per access, single ack/err to the master.
// Build option WB_DEC_UNMAPPED_ERR_EN: unpopulated blocks answer with err instead of a dummy ack.
module wb_dec
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES  = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WB_ADDR_W-1:0] wb_addr_i,
  input  logic [WB_DAT_W-1:0]  wb_dat_i,
  output logic                 s_cyc_o,
  output logic [WB_NBLK-1:0]   s_stb_o,
  output logic                 s_we_o,
  output logic [WB_OFS_W-1:0]  s_addr_o,
  output logic [WB_DAT_W-1:0]  s_dat_o,
  input  logic [WB_NBLK-1:0]   s_ack_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o
);

  wb_state_e           state_q;
  logic [WB_BLK_W-1:0] blk_q;
  logic                cyc_q, we_q, ack_q, err_q;
  logic [WB_NBLK-1:0]  stb_q;
  logic [WB_OFS_W-1:0] ofs_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic                req, mapped, wd_tc;

  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign mapped = int'(wb_addr_i[WB_ADDR_W-1:WB_OFS_W]) < NUM_SLAVES;

  wb_dec_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_wdog (
    .clk_i (wb_clk_i),
    .srst_i(wb_rst_i),
    .clr_i (state_q == ST_IDLE),
    .en_i  (state_q == ST_ACTIVE),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      ofs_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            blk_q <= wb_addr_i[WB_ADDR_W-1:WB_OFS_W];
            ofs_q <= wb_addr_i[WB_OFS_W-1:0];
            dat_q <= wb_dat_i;
            we_q  <= wb_we_i;
            if (mapped) begin
              state_q <= ST_ACTIVE;
              cyc_q   <= 1'b1;
              stb_q   <= blk_onehot(wb_addr_i[WB_ADDR_W-1:WB_OFS_W]);
            end else begin
              state_q <= ST_DONE;
`ifdef WB_DEC_UNMAPPED_ERR_EN
              err_q   <= 1'b1;
`else
              ack_q   <= 1'b1;
`endif
            end
          end
        end
        // Selected ack beats the watchdog, which beats a master abort.
        ST_ACTIVE: begin
          if (s_ack_i[blk_q]) begin
            state_q <= ST_DONE;
            ack_q   <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= '0;
          end else if (wd_tc) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= '0;
          end else if (!wb_cyc_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= '0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_cyc_o  = cyc_q;
  assign s_stb_o  = stb_q;
  assign s_we_o   = we_q;
  assign s_addr_o = ofs_q;
  assign s_dat_o  = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_dec.sv
// Randomized bench for wb_dec: a fully populated instance and a 4-slave instance, checked against
// per-transaction timelines derived from the decoder's access rules.
module tb_wb_dec;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [7:0]  addr  [2];
  logic [7:0]  dat   [2];
  logic [15:0] sack  [2];
  logic        scyc  [2];
  logic        swe   [2];
  logic        ack   [2];
  logic        err   [2];
  logic [15:0] sstb  [2];
  logic [3:0]  saddr [2];
  logic [7:0]  sdat  [2];

  logic [3:0]  e_ofs [2];
  logic [7:0]  e_dat [2];
  logic        e_we  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wb_dec #(
      .NUM_SLAVES ((gi == 0) ? 16 : 4),
      .TIMEOUT_CYC(T),
      .TO_W       (8)
    ) u_dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_cyc_i (cyc[gi]),
      .wb_stb_i (stb[gi]),
      .wb_we_i  (we[gi]),
      .wb_addr_i(addr[gi]),
      .wb_dat_i (dat[gi]),
      .s_cyc_o  (scyc[gi]),
      .s_stb_o  (sstb[gi]),
      .s_we_o   (swe[gi]),
      .s_addr_o (saddr[gi]),
      .s_dat_o  (sdat[gi]),
      .s_ack_i  (sack[gi]),
      .wb_ack_o (ack[gi]),
      .wb_err_o (err[gi])
    );
  end

  function automatic int ns_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int k, input logic [15:0] xs, input logic xc,
                            input logic xa, input logic xe, input string ph);
    chk($sformatf("%s%0d.stb", ph, k), 32'(sstb[k]), 32'(xs));
    chk($sformatf("%s%0d.cyc", ph, k), 32'(scyc[k]), 32'(xc));
    chk($sformatf("%s%0d.ack", ph, k), 32'(ack[k]), 32'(xa));
    chk($sformatf("%s%0d.err", ph, k), 32'(err[k]), 32'(xe));
    chk($sformatf("%s%0d.ofs", ph, k), 32'(saddr[k]), 32'(e_ofs[k]));
    chk($sformatf("%s%0d.dat", ph, k), 32'(sdat[k]), 32'(e_dat[k]));
    chk($sformatf("%s%0d.we", ph, k), 32'(swe[k]), 32'(e_we[k]));
  endtask

  // ack_dly: first cycle (0 = first strobe cycle) the selected slave acks, -1 never.
  // abort_at: first cycle the master holds cyc low, -1 never.
  // keep: leave cyc/stb high after the response so the next call forms a back-to-back access.
  task automatic run_txn(input int k, input logic [7:0] a, input logic [7:0] d, input logic w,
                         input int ack_dly, input int abort_at, input logic [15:0] noise,
                         input bit keep);
    logic [15:0] sel;
    int          end_j;
    int          kind;
    bit          mapped;
    sel    = 16'h1 << a[7:4];
    mapped = int'(a[7:4]) < ns_of(k);
    end_j  = 0;
    kind   = 0;
    if (!mapped) begin
`ifdef WB_DEC_UNMAPPED_ERR_EN
      kind = 2;
`else
      kind = 1;
`endif
      sel = 16'h0;
    end else begin
      for (int j = 1; j <= T + 1 && kind == 0; j++) begin
        if (ack_dly >= 0 && j - 1 >= ack_dly) kind = 1;
        else if (j - 1 >= T)                  kind = 2;
        else if (abort_at >= 0 && j - 1 >= abort_at) kind = 3;
        end_j = j;
      end
    end
    cyc[k]  = 1'b1;
    stb[k]  = 1'b1;
    addr[k] = a;
    dat[k]  = d;
    we[k]   = w;
    sack[k] = noise & ~(16'h1 << a[7:4]);
    e_ofs[k] = a[3:0];
    e_dat[k] = d;
    e_we[k]  = w;
    for (int c = 0; c <= end_j; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < end_j) check_outs(k, sel, 1'b1, 1'b0, 1'b0, "act");
      else           check_outs(k, 16'h0, 1'b0, kind == 1, kind == 2, "rsp");
      addr[k] = 8'($urandom);
      dat[k]  = 8'($urandom);
      we[k]   = 1'($urandom);
      sack[k] = noise & ~(16'h1 << a[7:4]);
      if (mapped && ack_dly >= 0 && c >= ack_dly) sack[k] = sack[k] | sel;
      cyc[k] = !(abort_at >= 0 && c >= abort_at);
      if (c == end_j) begin
        cyc[k]  = keep;
        stb[k]  = keep;
        sack[k] = 16'h0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outs(k, 16'h0, 1'b0, 1'b0, 1'b0, "idl");
    $display("txn inst=%0d addr=%02h dat=%02h we=%0d ack_dly=%0d abort_at=%0d kind=%0d resp_cyc=%0d",
             k, a, d, w, ack_dly, abort_at, kind, end_j);
  endtask

  task automatic idle_cycles(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      cyc[k]  = 1'($urandom);
      stb[k]  = ~cyc[k] & 1'($urandom);
      addr[k] = 8'($urandom);
      dat[k]  = 8'($urandom);
      we[k]   = 1'($urandom);
      sack[k] = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_outs(k, 16'h0, 1'b0, 1'b0, 1'b0, "gap");
    end
    cyc[k]  = 1'b0;
    stb[k]  = 1'b0;
    sack[k] = 16'h0;
  endtask

  task automatic reset_mid(input int k);
    cyc[k]  = 1'b1;
    stb[k]  = 1'b1;
    addr[k] = 8'h27;
    dat[k]  = 8'h5C;
    we[k]   = 1'b1;
    sack[k] = 16'h0;
    e_ofs[k] = 4'h7;
    e_dat[k] = 8'h5C;
    e_we[k]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs(k, 16'h0004, 1'b1, 1'b0, 1'b0, "pre");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e_ofs[i] = 4'h0;
      e_dat[i] = 8'h00;
      e_we[i]  = 1'b0;
      check_outs(i, 16'h0, 1'b0, 1'b0, 1'b0, "rst");
    end
    rst    = 1'b0;
    cyc[k] = 1'b0;
    stb[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outs(k, 16'h0, 1'b0, 1'b0, 1'b0, "prst");
    $display("txn inst=%0d reset during active access", k);
  endtask

  initial begin
    int k;
    int ad;
    int ab;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      addr[i] = 8'h00; dat[i] = 8'h00; sack[i] = 16'h0;
      e_ofs[i] = 4'h0; e_dat[i] = 8'h00; e_we[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outs(i, 16'h0, 1'b0, 1'b0, 1'b0, "init");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    run_txn(0, 8'h35, 8'hA5, 1'b1, 2, -1, 16'h0, 1'b0);          // write, slave 3 acks late
    run_txn(0, 8'h20, 8'h11, 1'b0, -1, -1, 16'h0, 1'b0);         // hung slave -> err
    run_txn(0, 8'h1C, 8'h3E, 1'b0, 3, -1, 16'h0004, 1'b0);       // wrong acker held
    run_txn(0, 8'h4A, 8'h77, 1'b1, -1, 1, 16'h0, 1'b0);          // master abort
    run_txn(0, 8'h00, 8'h01, 1'b1, 1, -1, 16'h0, 1'b1);          // back-to-back pair
    run_txn(0, 8'hF0, 8'h02, 1'b1, 1, -1, 16'h0, 1'b0);
    run_txn(1, 8'h90, 8'hC3, 1'b1, 0, -1, 16'hFFFF, 1'b0);       // unpopulated block
    run_txn(1, 8'h3F, 8'h9A, 1'b0, 4, -1, 16'h0, 1'b0);          // last populated block
    reset_mid(0);

    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 1));
      ad = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_txn(k, 8'($urandom), 8'($urandom), 1'($urandom), ad, ab, 16'($urandom), 1'b0);
      idle_cycles(k, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
